fifo_sync: RTL
==============

FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload width in bits, 1..16.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9: depth = 2**ADDR_WIDTH entries, 8..11.
REQ-003 SHALL have parameter AF_LEVEL, default 2**ADDR_WIDTH-4: almost_full asserts when level >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 4: almost_empty asserts when level <= AE_LEVEL.
REQ-005 SHALL have parameter FWFT, default 0: 0 = standard read, 1 = first-word-fall-through.
REQ-006 SHALL have the ports below, one per line; one clock; reset is asynchronous and active-low:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush; discards contents.
- we  in  1  write request.
- d  in  DATA_WIDTH  write data.
- re  in  1  read request (FWFT=1: pop/acknowledge).
- q  out  DATA_WIDTH  read data.
- empty  out  1  no data readable.
- full  out  1  no space.
- almost_full  out  1  level >= AF_LEVEL.
- almost_empty  out  1  level <= AE_LEVEL.
- level  out  ADDR_WIDTH+1  occupancy, 0..2**ADDR_WIDTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Function
REQ-007 SHALL accept a write when we & ~full; the write is stored at waddr, and waddr increments modulo depth.
REQ-008 SHALL accept a read when re & ~empty; raddr increments modulo depth.
REQ-009 FWFT=0: q SHALL present the accepted word one cycle after the accepting edge and hold it until the next accepted read.
REQ-010 FWFT=1: q SHALL present the head word whenever empty=0; an accepted read SHALL present the next word (or assert empty) on the following cycle.
REQ-011 FWFT=1: a word written to an empty FIFO SHALL appear on q with empty=0 no later than 3 cycles after the write edge; level counts the word from the write edge.
REQ-012 level SHALL increment on write-only, decrement on read-only, and hold on a simultaneous accepted write and read.
REQ-013 When full, a simultaneous we & re SHALL accept the read only; level decrements; overflow is set.
REQ-014 When empty, a simultaneous we & re SHALL accept the write only; underflow is set.
REQ-015 full, empty, almost_full and almost_empty SHALL be registered outputs, consistent with level in the same cycle and free of combinational paths from we or re.
REQ-016 overflow SHALL set on we & full, and underflow on re & empty; both are cleared only by reset or clr.
REQ-017 clr SHALL take priority over we and re: next cycle level=0, pointers=0, empty=1, flags cleared; q holds its value.
REQ-018 Storage SHALL be a single clk-domain dual-port RAM with a registered read port; read-during-write to the same address never occurs by construction.
REQ-019 Address arithmetic SHALL use ADDR_WIDTH-bit pointers with natural wrap and an (ADDR_WIDTH+1)-bit level counter; there is no saturation logic beyond the full and empty gating.

Reset
REQ-020 While rst_n=0: pointers=0, level=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, q=0.
REQ-021 Reset asserted mid-operation SHALL discard all contents immediately; RAM contents are don't-care after reset.
REQ-022 Reset release SHALL be synchronised externally; the first accepted write may occur on the first clk edge with rst_n=1.

Structure
REQ-023 The shared package fifo_pkg SHALL hold the FWFT mode constants (FIFO_STD=0, FIFO_FWFT=1) and the DATA_WIDTH and ADDR_WIDTH legal-range constants.
REQ-024 A single sub-module fifo_sync_ram SHALL wrap the storage, mapping to SB_RAM40_4K in the 256x16, 512x8, 1024x4 or 2048x2 mode selected from ADDR_WIDTH; the mode lookup lives in fifo_pkg.
REQ-025 The FWFT output prefetch register and its control SHALL reside in fifo_sync, generated only when FWFT=1.

Verification
REQ-026 Fill: ADDR_WIDTH=8, FWFT=0, 256 writes of 0..255 -> full=1 and level=256 after the last write; a 257th write sets overflow and level stays 256.
REQ-027 Drain: read 256 words -> q sequence 0..255 with 1-cycle latency and empty=1 after the last read; an extra read sets underflow and q holds 255.
REQ-028 Simultaneous: level=10, we=re=1 for 20 cycles -> level remains 10 and data order is preserved; at full, we=re=1 -> level becomes 255 and overflow=1.
REQ-029 FWFT=1: a single write of 0xA5 to an empty FIFO -> q=0xA5 with empty=0 within 3 cycles; re=1 -> empty=1 on the next cycle.
REQ-030 Thresholds: AF_LEVEL=250, AE_LEVEL=4 -> almost_full rises on the 250th write and almost_empty falls on the 5th write.
REQ-031 Reset and clear: rst_n pulsed low at level=100 -> all outputs take their REQ-020 values; clr at level=50 -> level=0 and empty=1 next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO: read-mode selectors, legal parameter
// ranges and the SB_RAM40_4K geometry lookup used by the storage wrapper.
package fifo_pkg;

    localparam int unsigned FIFO_STD  = 0;
    localparam int unsigned FIFO_FWFT = 1;

    localparam int unsigned DATA_WIDTH_MIN = 1;
    localparam int unsigned DATA_WIDTH_MAX = 16;
    localparam int unsigned ADDR_WIDTH_MIN = 8;
    localparam int unsigned ADDR_WIDTH_MAX = 11;

    typedef enum logic [1:0] {
        RAM_256X16,
        RAM_512X8,
        RAM_1024X4,
        RAM_2048X2
    } ram_mode_e;

    // Block RAM aspect ratio whose depth matches the FIFO depth
    function automatic ram_mode_e ram_mode(input int unsigned addr_width);
        case (addr_width)
            8:       return RAM_256X16;
            9:       return RAM_512X8;
            10:      return RAM_1024X4;
            default: return RAM_2048X2;
        endcase
    endfunction

    function automatic int unsigned ram_lane_width(input ram_mode_e mode);
        case (mode)
            RAM_256X16: return 16;
            RAM_512X8:  return 8;
            RAM_1024X4: return 4;
            default:    return 2;
        endcase
    endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Simple dual-port storage with a registered read port, split into lanes that
// each fit one SB_RAM40_4K in the aspect ratio chosen from ADDR_WIDTH.
module fifo_sync_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam ram_mode_e   MODE   = ram_mode(ADDR_WIDTH);
    localparam int unsigned LANE_W = ram_lane_width(MODE);
    localparam int unsigned LANES  = (DATA_WIDTH + LANE_W - 1) / LANE_W;
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        // Last lane may be narrower than the block RAM port
        localparam int unsigned LO = g * LANE_W;
        localparam int unsigned W  = (DATA_WIDTH - LO < LANE_W) ? (DATA_WIDTH - LO) : LANE_W;

        logic [W-1:0] r_mem [DEPTH];
        logic [W-1:0] r_rdata;

        always_ff @(posedge i_clk) begin
            if (i_we) begin
                r_mem[i_waddr] <= i_wdata[LO +: W];
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_rdata <= '0;
            end else if (i_re) begin
                r_rdata <= r_mem[i_raddr];
            end
        end

        assign o_rdata[LO +: W] = r_rdata;
    end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered status flags, sticky over/underflow and an
// optional first-word-fall-through output stage.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned AF_LEVEL   = (1 << ADDR_WIDTH) - 4,
    parameter int unsigned AE_LEVEL   = 4,
    parameter int unsigned FWFT       = FIFO_STD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned LVL_W = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [LVL_W-1:0]      r_level;
    logic [LVL_W-1:0]      w_level_nxt;
    logic                  r_full;
    logic                  r_af;
    logic                  r_ae;
    logic                  r_ov;
    logic                  r_uf;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_ram_re;
    logic [DATA_WIDTH-1:0] w_ram_q;
    logic [DATA_WIDTH-1:0] w_q;

    assign w_wr_acc = we & ~r_full & ~clr;
    assign w_rd_acc = re & ~w_empty & ~clr;

    always_comb begin
        w_level_nxt = r_level;
        if (clr) begin
            w_level_nxt = '0;
        end else begin
            w_level_nxt = r_level + LVL_W'(w_wr_acc) - LVL_W'(w_rd_acc);
        end
    end

    // Pointers, occupancy and flags; flags come from next level so they track level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
            r_ov    <= 1'b0;
            r_uf    <= 1'b0;
        end else begin
            if (clr) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_ov   <= 1'b0;
                r_uf   <= 1'b0;
            end else begin
                if (w_wr_acc) r_wptr <= r_wptr + ADDR_WIDTH'(1);
                if (w_ram_re) r_rptr <= r_rptr + ADDR_WIDTH'(1);
                r_ov <= r_ov | (we & r_full);
                r_uf <= r_uf | (re & w_empty);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_W'(DEPTH));
            r_af    <= (w_level_nxt >= LVL_W'(AF_LEVEL));
            r_ae    <= (w_level_nxt <= LVL_W'(AE_LEVEL));
        end
    end

    fifo_sync_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_we    (w_wr_acc),
        .i_waddr (r_wptr),
        .i_wdata (d),
        .i_re    (w_ram_re),
        .i_raddr (r_rptr),
        .o_rdata (w_ram_q)
    );

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // Two-deep prefetch: RAM output register (stage 1) feeding the q register
        logic                  r_s1_valid;
        logic                  r_q_valid;
        logic [DATA_WIDTH-1:0] r_q;
        logic                  w_s1_move;
        logic                  w_fetch;
        logic [LVL_W-1:0]      w_in_flight;

        assign w_in_flight = LVL_W'(r_s1_valid) + LVL_W'(r_q_valid);
        assign w_s1_move   = r_s1_valid & (~r_q_valid | w_rd_acc);
        assign w_fetch     = (r_level > w_in_flight) & (~r_s1_valid | w_s1_move) & ~clr;
        assign w_ram_re    = w_fetch;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1_valid <= 1'b0;
                r_q_valid  <= 1'b0;
                r_q        <= '0;
            end else if (clr) begin
                r_s1_valid <= 1'b0;
                r_q_valid  <= 1'b0;
            end else begin
                if (w_s1_move) r_q <= w_ram_q;
                r_q_valid  <= w_s1_move | (r_q_valid & ~w_rd_acc);
                r_s1_valid <= w_fetch | (r_s1_valid & ~w_s1_move);
            end
        end

        assign w_q     = r_q;
        assign w_empty = ~r_q_valid;
    end else begin : g_std
        logic r_empty;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_empty <= 1'b1;
            end else begin
                r_empty <= (w_level_nxt == '0);
            end
        end

        assign w_ram_re = w_rd_acc;
        assign w_q      = w_ram_q;
        assign w_empty  = r_empty;
    end

    assign q            = w_q;
    assign empty        = w_empty;
    assign full         = r_full;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign level        = r_level;
    assign overflow     = r_ov;
    assign underflow    = r_uf;

endmodule
